ddu_write_unit: RTL and testbench

- Debug write-entry unit; the input-side counterpart of the debug display path.
- The operator enters a 32-bit hex value one digit at a time from switches and buttons. The block then commits that value into CPU memory at a switch-selected address through a request/acknowledge write port.
- Sits between board buttons/switches and the CPU debug write port; `entry_data` feeds the 7-segment display mux for live echo.

---
 rtl/ddu_write_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_ddu_write_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddu_write_unit.sv
// ddu_write_unit: debug write-entry unit. Buttons enter a 32-bit hex word
// digit by digit and commit it to CPU memory over a req/ack write port.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   btn_digit         raw button, shift sw_hex into the entry
//   btn_commit        raw button, write the entry to sw_addr
//   btn_clear         raw button, clear entry and err
//   sw_hex[3:0]       digit to enter
//   sw_addr[ADDR_W]   target word address
//   wr_req/addr/data  write request, address, data
//   wr_ack            CPU accepted the write
//   entry_data[31:0]  current entry (display echo)
//   digit_cnt[3:0]    digits entered, saturates at 8
//   busy              write in flight (REQ or DONE)
//   err               sticky ack-timeout flag

// ddu_btn_cond: per-button conditioning.
// 2-flop sync, stable-count debounce, one-clk pulse on debounced rise.
module ddu_btn_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        // only the debounced rising edge is a press
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

module ddu_write_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned ACK_TIMEOUT     = 1024,
  parameter int unsigned ADDR_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_digit,
  input  logic              btn_commit,
  input  logic              btn_clear,
  input  logic [3:0]        sw_hex,
  input  logic [ADDR_W-1:0] sw_addr,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ack,
  output logic [31:0]       entry_data,
  output logic [3:0]        digit_cnt,
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  logic p_digit, p_commit, p_clear;
  logic sel_clear, sel_commit, sel_digit;

  logic [1:0]        state_q, state_d;
  logic              wr_req_q, wr_req_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [31:0]       entry_q, entry_d;
  logic [3:0]        dcnt_q, dcnt_d;
  logic              err_q, err_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  ddu_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_digit (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_digit),
    .press   (p_digit)
  );

  ddu_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_commit),
    .press   (p_commit)
  );

  ddu_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_clear),
    .press   (p_clear)
  );

  // clear > commit > digit; losers in the same cycle are dropped
  assign sel_clear  = p_clear;
  assign sel_commit = p_commit & ~p_clear;
  assign sel_digit  = p_digit & ~p_commit & ~p_clear;

  always_comb begin
    state_d   = state_q;
    wr_req_d  = wr_req_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    entry_d   = entry_q;
    dcnt_d    = dcnt_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          sel_clear: begin
            entry_d = '0;
            dcnt_d  = '0;
            err_d   = 1'b0;
          end
          sel_commit: begin
            if (dcnt_q != 4'd0) begin
              wr_addr_d = sw_addr;
              wr_data_d = entry_q;
              wr_req_d  = 1'b1;
              tmo_d     = '0;
              state_d   = S_REQ;
            end
          end
          sel_digit: begin
            entry_d = {entry_q[27:0], sw_hex};
            dcnt_d  = (dcnt_q == 4'd8) ? 4'd8 : dcnt_q + 4'd1;
          end
          default: ;
        endcase
      end
      S_REQ: begin
        if (wr_ack) begin
          wr_req_d = 1'b0;
          entry_d  = '0;
          dcnt_d   = '0;
          state_d  = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          // entry kept so the operator can retry
          wr_req_d = 1'b0;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        wr_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      entry_q   <= '0;
      dcnt_q    <= '0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      entry_q   <= entry_d;
      dcnt_q    <= dcnt_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign wr_req     = wr_req_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign entry_data = entry_q;
  assign digit_cnt  = dcnt_q;
  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_ddu_write_unit.sv
// tb_ddu_write_unit: table vectors, directed corner sequences and
// randomized ops against a word-level model of ddu_write_unit.
module tb_ddu_write_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_digit, btn_commit, btn_clear;
  logic [3:0]  sw_hex;
  logic [7:0]  sw_addr;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic [31:0] entry_data;
  logic [3:0]  digit_cnt;
  logic        busy, err;

  always #5 clk = ~clk;

  ddu_write_unit #(
    .DEBOUNCE_CYCLES(4),
    .ACK_TIMEOUT    (16),
    .ADDR_W         (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_digit  (btn_digit),
    .btn_commit (btn_commit),
    .btn_clear  (btn_clear),
    .sw_hex     (sw_hex),
    .sw_addr    (sw_addr),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .entry_data (entry_data),
    .digit_cnt  (digit_cnt),
    .busy       (busy),
    .err        (err)
  );

  typedef struct {
    logic [3:0]  hex;
    logic        clr;
    logic [31:0] exp_entry;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs[11];

  int tests = 0;
  int fails = 0;

  logic [31:0] m_entry;
  int          m_cnt;
  logic        m_err;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string nm);
    chk({nm, ".entry"}, entry_data, m_entry);
    chk({nm, ".cnt"}, 32'(digit_cnt), 32'(m_cnt));
    chk({nm, ".err"}, 32'(err), 32'(m_err));
  endtask

  function automatic void m_digit(input logic [3:0] h);
    m_entry = (m_entry << 4) | 32'(h);
    m_cnt   = (m_cnt < 8) ? m_cnt + 1 : 8;
  endfunction

  function automatic void m_clear();
    m_entry = 0;
    m_cnt   = 0;
    m_err   = 1'b0;
  endfunction

  // mask: bit0 digit, bit1 commit, bit2 clear
  task automatic press(input logic [2:0] mask, output logic [31:0] e6,
                       output logic [31:0] e7);
    e6 = '0;
    e7 = '0;
    btn_digit  = mask[0];
    btn_commit = mask[1];
    btn_clear  = mask[2];
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (t == 6) e6 = entry_data;
      if (t == 7) e7 = entry_data;
      if (t == 8) begin
        btn_digit  = 1'b0;
        btn_commit = 1'b0;
        btn_clear  = 1'b0;
      end
    end
  endtask

  task automatic do_digit(input logic [3:0] h);
    logic [31:0] e6, e7;
    sw_hex = h;
    press(3'b001, e6, e7);
    m_digit(h);
  endtask

  task automatic do_clear();
    logic [31:0] e6, e7;
    press(3'b100, e6, e7);
    m_clear();
  endtask

  // commit press; CPU acks k cycles after wr_req rises
  task automatic do_commit(input logic [7:0] addr, input int k,
                           input bit poke);
    int          n = -1;
    int          len = 0;
    int          exp_len;
    bit          stable = 1'b1;
    bit          dropped = 1'b0;
    bit          idle_next = 1'b0;
    logic [7:0]  a0 = '0;
    logic [31:0] d0 = '0;
    if (m_cnt == 0) exp_len = 0;
    else if (k <= 15) exp_len = k + 1;
    else exp_len = 16;
    sw_addr    = addr;
    btn_commit = 1'b1;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (t == 8) btn_commit = 1'b0;
      if (poke && t == 8) btn_digit = 1'b1;
      if (poke && t == 16) btn_digit = 1'b0;
      if (idle_next) begin
        chk("commit.busy_idle", 32'(busy), 32'd0);
        idle_next = 1'b0;
      end
      if (wr_req) begin
        if (n < 0) begin
          n  = 0;
          a0 = wr_addr;
          d0 = wr_data;
          chk("commit.addr", 32'(wr_addr), 32'(addr));
          chk("commit.data", wr_data, m_entry);
        end else begin
          n++;
          if (wr_addr !== a0 || wr_data !== d0) stable = 1'b0;
        end
        len++;
        sw_addr = 8'($urandom);
        wr_ack  = (n >= k);
      end else begin
        wr_ack = 1'b0;
        if (n >= 0 && !dropped) begin
          dropped = 1'b1;
          chk("commit.busy_done", 32'(busy), 32'd1);
          idle_next = 1'b1;
        end
      end
    end
    wr_ack = 1'b0;
    chk("commit.len", 32'(len), 32'(exp_len));
    chk("commit.stable", 32'(stable), 32'd1);
    if (m_cnt != 0) begin
      if (k <= 15) begin
        m_entry = 0;
        m_cnt   = 0;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  initial begin
    logic [31:0] e6, e7;
    rst_n      = 1'b0;
    btn_digit  = 1'b0;
    btn_commit = 1'b0;
    btn_clear  = 1'b0;
    sw_hex     = '0;
    sw_addr    = '0;
    wr_ack     = 1'b0;
    m_entry    = 0;
    m_cnt      = 0;
    m_err      = 1'b0;

    vecs[0]  = '{4'h1, 1'b0, 32'h00000001, 4'd1};
    vecs[1]  = '{4'h2, 1'b0, 32'h00000012, 4'd2};
    vecs[2]  = '{4'h3, 1'b0, 32'h00000123, 4'd3};
    vecs[3]  = '{4'h4, 1'b0, 32'h00001234, 4'd4};
    vecs[4]  = '{4'h5, 1'b0, 32'h00012345, 4'd5};
    vecs[5]  = '{4'h6, 1'b0, 32'h00123456, 4'd6};
    vecs[6]  = '{4'h7, 1'b0, 32'h01234567, 4'd7};
    vecs[7]  = '{4'h8, 1'b0, 32'h12345678, 4'd8};
    vecs[8]  = '{4'h9, 1'b0, 32'h23456789, 4'd8};
    vecs[9]  = '{4'hA, 1'b0, 32'h3456789A, 4'd8};
    vecs[10] = '{4'h0, 1'b1, 32'h00000000, 4'd0};

    repeat (3) tick();
    chk("rst.wr_req", 32'(wr_req), 32'd0);
    chk("rst.wr_addr", 32'(wr_addr), 32'd0);
    chk("rst.wr_data", wr_data, 32'd0);
    chk("rst.entry", entry_data, 32'd0);
    chk("rst.cnt", 32'(digit_cnt), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 11; i++) begin
      sw_hex = vecs[i].hex;
      press(vecs[i].clr ? 3'b100 : 3'b001, e6, e7);
      if (i == 0) begin
        chk("lat.before", e6, 32'd0);
        chk("lat.after", e7, 32'd1);
      end
      chk($sformatf("vec%0d.entry", i), entry_data, vecs[i].exp_entry);
      chk($sformatf("vec%0d.cnt", i), 32'(digit_cnt),
          32'(vecs[i].exp_cnt));
    end
    m_clear();

    // commit handshake, ack 3 cycles after req
    do_digit(4'hD); do_digit(4'hE); do_digit(4'hA); do_digit(4'hD);
    do_digit(4'hB); do_digit(4'hE); do_digit(4'hE); do_digit(4'hF);
    chk("hs.entry_pre", entry_data, 32'hDEADBEEF);
    do_commit(8'h1F, 3, 1'b0);
    check_state("hs");
    chk("hs.entry_zero", entry_data, 32'd0);

    // timeout with a digit press during REQ
    do_digit(4'h1); do_digit(4'h2); do_digit(4'h3); do_digit(4'h4);
    do_commit(8'h42, 100, 1'b1);
    check_state("tmo");
    chk("tmo.err", 32'(err), 32'd1);
    chk("tmo.entry", entry_data, 32'h00001234);
    do_clear();
    check_state("tmo_clr");

    // commit with nothing entered
    do_commit(8'h05, 0, 1'b0);
    check_state("empty_commit");

    // clear and digit coincide
    do_digit(4'h7); do_digit(4'h8);
    sw_hex = 4'h9;
    press(3'b101, e6, e7);
    chk("prio.entry", entry_data, 32'd0);
    chk("prio.cnt", 32'(digit_cnt), 32'd0);
    m_clear();

    // bounce 1-0-1-0 at 2-cycle spacing, then held
    sw_hex = 4'h5;
    for (int i = 0; i < 4; i++) begin
      btn_digit = ~i[0];
      repeat (2) tick();
    end
    btn_digit = 1'b1;
    repeat (10) tick();
    btn_digit = 1'b0;
    repeat (8) tick();
    m_digit(4'h5);
    check_state("bounce");

    // reset in the middle of REQ
    do_digit(4'hC);
    sw_addr    = 8'hAA;
    btn_commit = 1'b1;
    repeat (10) tick();
    chk("rstreq.req_pre", 32'(wr_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstreq.wr_req", 32'(wr_req), 32'd0);
    chk("rstreq.wr_addr", 32'(wr_addr), 32'd0);
    chk("rstreq.wr_data", wr_data, 32'd0);
    chk("rstreq.entry", entry_data, 32'd0);
    chk("rstreq.cnt", 32'(digit_cnt), 32'd0);
    chk("rstreq.busy", 32'(busy), 32'd0);
    btn_commit = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    m_entry = 0;
    m_cnt   = 0;
    m_err   = 1'b0;

    for (int i = 0; i < 150; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 5) do_digit(4'($urandom));
      else if (op == 6) do_clear();
      else do_commit(8'($urandom), $urandom_range(0, 20), 1'b0);
      check_state($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
